// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix result streamer.
// Holds the bank geometry, element/index types and the stream FSM states.
package matrix_pkg;

  localparam int DIM    = 3;
  localparam int N_ELEM = DIM * DIM;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/matrix_index_gen.sv
// Row/col emit-order counters for the result streamer.
// Ports: clk, rst_n, advance, clear in; index (bank select), last out.
module matrix_index_gen #(
  parameter int DIM       = 3,
  parameter int IDX_W     = 4,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             clear,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] MAXC = CW'(DIM - 1);

  // row is the outer counter, col the inner one, in emit order
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  int            e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAXC) begin
        col <= '0;
        row <= (row == MAXC) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    e = 0;
    if (COL_MAJOR)
      e = int'(col) * DIM + int'(row);
    else
      e = int'(row) * DIM + int'(col);
    index = IDX_W'(e);
    last  = (row == MAXC) && (col == MAXC);
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots the 3x3 result bank on start and streams it out beat by beat.
// Ports: clk, rst_n, start, mat_in, out_ready in; out_valid/data/index/last, busy, done out.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIM       = 3,
  parameter int IDX_W     = 4,
  parameter bit COL_MAJOR = 1'b0,
  localparam int N_ELEM   = DIM * DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_ELEM*DATA_W-1:0] mat_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  stream_state_t     state;
  stream_state_t     state_n;
  logic [DATA_W-1:0] snap [N_ELEM];
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic              advance;
  logic              clear;

  matrix_index_gen #(
    .DIM       (DIM),
    .IDX_W     (IDX_W),
    .COL_MAJOR (COL_MAJOR)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .clear   (clear),
    .index   (idx),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // private copy lets the producer reuse the bank mid-pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_ELEM; j++)
        snap[j] <= '0;
    end else if (state == IDLE && start) begin
      for (int j = 0; j < N_ELEM; j++)
        snap[j] <= mat_in[j*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n = state;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          clear   = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          advance = 1'b1;
          if (last)
            state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    done      = (state == DONE);
    out_data  = out_valid ? snap[idx] : '0;
    out_index = out_valid ? idx : '0;
    out_last  = out_valid & last;
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer, row- and column-major builds.
// Each task drives one scenario and checks its own observations inline.
module tb_matrix_result_streamer;

  localparam int DW = 32;
  localparam int NE = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NE*DW-1:0] mat_in = '0;
  logic             start_r = 1'b0;
  logic             start_c = 1'b0;
  logic             ready_r = 1'b0;
  logic             ready_c = 1'b0;

  logic          r_valid, c_valid;
  logic [DW-1:0] r_data, c_data;
  logic [3:0]    r_index, c_index;
  logic          r_last, c_last;
  logic          r_busy, c_busy;
  logic          r_done, c_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_result_streamer #(.COL_MAJOR(1'b0)) dut_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_r),
    .mat_in    (mat_in),
    .out_ready (ready_r),
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_index (r_index),
    .out_last  (r_last),
    .busy      (r_busy),
    .done      (r_done)
  );

  matrix_result_streamer #(.COL_MAJOR(1'b1)) dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .mat_in    (mat_in),
    .out_ready (ready_c),
    .out_valid (c_valid),
    .out_data  (c_data),
    .out_index (c_index),
    .out_last  (c_last),
    .busy      (c_busy),
    .done      (c_done)
  );

  task automatic set_mat(input logic [DW-1:0] base, input bit same);
    for (int j = 0; j < NE; j++)
      mat_in[j*DW +: DW] = same ? base : base + DW'(j);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string name, input int act, input int exp);
    errors++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({r_valid, r_busy, r_done, r_last} !== 4'b0)
      fail("reset_ctl_r", {r_valid, r_busy, r_done, r_last}, 0);
    checks++;
    if ({c_valid, c_busy, c_done, c_last} !== 4'b0)
      fail("reset_ctl_c", {c_valid, c_busy, c_done, c_last}, 0);
    checks++;
    if (r_data !== 32'h0 || r_index !== 4'h0)
      fail("reset_data_r", r_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (r_valid !== 1'b0 || c_valid !== 1'b0)
      fail("idle_no_start", {r_valid, c_valid}, 0);
  endtask

  // pulse start and confirm first beat appears one cycle later
  task automatic start_pass(input bit col);
    if (col) start_c = 1'b1;
    else     start_r = 1'b1;
    tick();
    start_r = 1'b0;
    start_c = 1'b0;
    checks++;
    if ((col ? c_valid : r_valid) !== 1'b1)
      fail("first_valid", col ? c_valid : r_valid, 1);
    checks++;
    if ((col ? c_busy : r_busy) !== 1'b1)
      fail("first_busy", col ? c_busy : r_busy, 1);
  endtask

  // consume one pass; stall_at/stall_n give back-pressure, start_at
  // pulses a stray start, abort_at drops rst_n on that beat
  task automatic stream_check(input bit col, input logic [DW-1:0] base,
                              input int stall_at, input int stall_n,
                              input int start_at, input int abort_at);
    int k = 0;
    int stalled = 0;
    bit want_done = 1'b0;
    bit got_done = 1'b0;
    logic v, l, b, d;
    logic [DW-1:0] dat;
    logic [3:0] ix;
    int exp_ix;
    for (int cyc = 0; cyc < 40; cyc++) begin
      v   = col ? c_valid : r_valid;
      l   = col ? c_last  : r_last;
      b   = col ? c_busy  : r_busy;
      d   = col ? c_done  : r_done;
      dat = col ? c_data  : r_data;
      ix  = col ? c_index : r_index;
      start_r = 1'b0;
      start_c = 1'b0;
      if (want_done) begin
        checks++;
        if (d !== 1'b1 || v !== 1'b0 || b !== 1'b0)
          fail("done_pulse", {d, v, b}, 4);
        got_done = 1'b1;
        break;
      end
      exp_ix = col ? ((k % 3) * 3 + k / 3) : k;
      if (v && int'(ix) == abort_at) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ((col ? c_valid : r_valid) !== 1'b0 ||
            (col ? c_busy : r_busy) !== 1'b0)
          fail("abort_now", {c_valid, c_busy, r_valid, r_busy}, 0);
        return;
      end
      if (v && int'(ix) == stall_at && stalled < stall_n) begin
        if (col) ready_c = 1'b0;
        else     ready_r = 1'b0;
        checks++;
        if (dat !== base + DW'(stall_at) || int'(ix) != stall_at || l !== 1'b0)
          fail("stall_hold", dat, base + DW'(stall_at));
        stalled++;
      end else begin
        if (col) ready_c = 1'b1;
        else     ready_r = 1'b1;
        if (v) begin
          checks++;
          if (int'(ix) != exp_ix)
            fail("beat_index", ix, exp_ix);
          checks++;
          if (dat !== base + DW'(exp_ix))
            fail("beat_data", dat, base + DW'(exp_ix));
          checks++;
          if (l !== (k == NE - 1))
            fail("beat_last", l, k == NE - 1);
          if (int'(ix) == start_at) begin
            if (col) start_c = 1'b1;
            else     start_r = 1'b1;
          end
          if (l) want_done = 1'b1;
          k++;
        end
      end
      tick();
    end
    ready_r = 1'b0;
    ready_c = 1'b0;
    checks++;
    if (k != NE) fail("beat_count", k, NE);
    checks++;
    if (!got_done) fail("done_timeout", 0, 1);
    checks++;
    if (stalled != stall_n) fail("stall_count", stalled, stall_n);
    tick();
    checks++;
    if ((col ? c_busy : r_busy) !== 1'b0 || (col ? c_done : r_done) !== 1'b0)
      fail("after_done", {c_busy, c_done, r_busy, r_done}, 0);
  endtask

  task automatic test_row_major();
    set_mat(32'h1000_0000, 1'b0);
    start_pass(1'b0);
    stream_check(1'b0, 32'h1000_0000, -1, 0, -1, -1);
  endtask

  task automatic test_col_major();
    set_mat(32'h1000_0000, 1'b0);
    start_pass(1'b1);
    stream_check(1'b1, 32'h1000_0000, -1, 0, -1, -1);
  endtask

  task automatic test_back_pressure();
    set_mat(32'h1000_0000, 1'b0);
    start_pass(1'b0);
    stream_check(1'b0, 32'h1000_0000, 4, 5, -1, -1);
  endtask

  task automatic test_snapshot();
    set_mat(32'h1000_0000, 1'b0);
    start_pass(1'b0);
    set_mat(32'hDEAD_BEEF, 1'b1);
    stream_check(1'b0, 32'h1000_0000, -1, 0, -1, -1);
    set_mat(32'h1000_0000, 1'b0);
  endtask

  task automatic test_ignored_start();
    start_pass(1'b0);
    stream_check(1'b0, 32'h1000_0000, -1, 0, 2, -1);
    tick();
    tick();
    checks++;
    if (r_valid !== 1'b0 || r_busy !== 1'b0)
      fail("no_extra_pass", {r_valid, r_busy}, 0);
  endtask

  task automatic test_reset_abort();
    bit saw_done = 1'b0;
    start_pass(1'b0);
    stream_check(1'b0, 32'h1000_0000, -1, 0, -1, 6);
    ready_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r_done || r_valid) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r_done || r_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) fail("abort_quiet", saw_done, 0);
    ready_r = 1'b0;
    start_pass(1'b0);
    stream_check(1'b0, 32'h1000_0000, -1, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_col_major();
    test_back_pressure();
    test_snapshot();
    test_ignored_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Reads out the 3x3 result bank (nine 32-bit words, element j at select code j) as a serial stream, one element per accepted beat, under valid/ready flow control.
- Sits between the result register file and the downstream consumer (host interface / output FIFO).
- Snapshots the whole bank on start so the producer may overwrite the bank while streaming is in progress.

Parameters:
- DATA_W, 32, element width in bits.
- DIM, 3, matrix dimension; N_ELEM = DIM*DIM = 9 (derived, not overridable).
- IDX_W, 4, width of the element index; must satisfy 2**IDX_W >= N_ELEM.
- COL_MAJOR, 0, 0 = emit row-major (0,1,2,...,8); 1 = emit column-major (0,3,6,1,4,7,2,5,8).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a readout pass; sampled only in IDLE.
- mat_in  in  N_ELEM*DATA_W  flattened bank; element j occupies bits [j*DATA_W +: DATA_W].
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_data  out  DATA_W  element value.
- out_index  out  IDX_W  bank select code (0..8) of the element in out_data.
- out_last  out  1  high on the final beat of the pass.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; row=0; col=0; snapshot cleared to 0. Outputs out_valid, out_data, out_index, out_last, busy, and done all read 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - On start=1 at edge k, capture all N_ELEM words of mat_in into the internal snapshot, set row=col=0, and go to STREAM.
  - out_valid is high from cycle k+1. Latency start->first valid = 1 cycle.
- STREAM:
  - out_valid=1 and busy=1.
  - Element index e is row*DIM+col when COL_MAJOR=0, and col*DIM+row when COL_MAJOR=1. Here row/col are the outer/inner counters in emit order: inner counter increments per beat and wraps DIM-1 -> 0 while incrementing the outer counter.
  - out_index = e; out_data = snapshot[e]; out_last = 1 when both counters equal DIM-1.
  - Beat accepted when out_valid & out_ready. On acceptance, advance the counters. If out_last is set, go to DONE and reset the counters to 0.
  - When out_ready=0, all outputs hold stable (no change in data, index, or last) until acceptance.
- DONE: done=1 for exactly one cycle, out_valid=0, busy=0, then IDLE unconditionally.
- Throughput: with out_ready held 1, nine consecutive valid beats, then done on the next cycle. A full pass is 1 (start) + 9 + 1 cycles, so the earliest next start is accepted in the cycle after done.
- start while in STREAM or DONE is ignored; it is not queued.
- mat_in changes after the start edge do not affect the current pass.
- rst_n asserted mid-pass aborts immediately to the reset state; no done pulse is produced. After release, the block idles until a fresh start.
- out_data, out_index, and out_last are forced to 0 whenever out_valid=0.

Decomposition:
- Shared package matrix_pkg:
  - DIM, N_ELEM, DATA_W, IDX_W constants.
  - typedef elem_t (logic [DATA_W-1:0]).
  - typedef idx_t (logic [IDX_W-1:0]).
  - enum stream_state_t {IDLE, STREAM, DONE}.
- One natural sub-module, matrix_index_gen: holds the row/col counters, computes the emit-order index (COL_MAJOR-aware), last flag, and wrap. Inputs are advance and clear; outputs are index and last.
- The snapshot array and the FSM stay in the top module.

Test Plan:
- Row-major, continuous ready: mat_in[j]=32'h1000_0000+j, start pulse, out_ready=1. Expect 9 beats with index 0..8 and data 10000000..10000008, last only on index 8, done one cycle after, busy low afterward.
- Column-major (COL_MAJOR=1), same data. Expect indices 0,3,6,1,4,7,2,5,8 with matching data, last on index 8.
- Back-pressure: hold out_ready=0 for 5 cycles on beat index 4. Expect data 10000004 and index 4 held stable with valid high throughout. The stream then resumes at index 5, and the total beat count is 9.
- Snapshot isolation: start, then change all mat_in words to 32'hDEAD_BEEF one cycle later. Expect the original 10000000..08 values streamed.
- Ignored start / reset abort: pulse start during beat 2 and check no effect or extra pass. Then drop rst_n during beat 6. Expect out_valid=0 and busy=0 immediately, no done pulse. After release plus start, a full pass from index 0 is produced.
